noc_output_port_vc: RTL and testbench

Next-generation router output port with NUM_VC virtual channels. Each VC has its own flit FIFO and its own credit counter that tracks free slots in the downstream input buffer. A round-robin arbiter picks one eligible VC per cycle and drives one registered flit onto the link. It replaces the single-channel output port and sits between the crossbar and the inter-router link.

---
 rtl/noc_output_port_vc.sv | 210 +++++++++++++++++++++
 tb/tb_noc_output_port_vc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_vc.sv
`default_nettype none
// ============================================================================
//  Module      : noc_output_port_vc
//  Description : Router output port with NUM_VC virtual channels. Each VC has
//                a flit FIFO and a credit counter that tracks free slots in
//                the downstream input buffer. A round-robin arbiter grants one
//                eligible VC per cycle and launches a registered flit.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_output_port_vc #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 5,
    parameter int NUM_VC  = 2,
    parameter int CREDITS = 5,
    parameter int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic [VC_W-1:0]   vc_i,
    input  logic              port_en,
    output logic [NUM_VC-1:0] full_o,
    input  logic [NUM_VC-1:0] inc_credit_i,
    output logic [DATA_W-1:0] data_o,
    output logic [VC_W-1:0]   vc_o,
    output logic              send_data,
    output logic              err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Per-VC status gathered from the generate loop
    logic [NUM_VC-1:0]             w_elig;
    logic [NUM_VC-1:0]             w_cred_ovf;
    logic [NUM_VC-1:0][DATA_W-1:0] w_head;
    logic [NUM_VC-1:0][CNT_W-1:0]  w_credit;

    // Arbitration results
    logic              w_grant_valid;
    logic [VC_W-1:0]   w_grant_vc;
    logic [VC_W:0]     w_sum;
    logic [VC_W-1:0]   w_ptr_next;

    // Push-side decode
    logic              w_vc_ok;
    logic              w_full_sel;
    logic              w_drop;

    // Registered state
    logic [VC_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0] r_data_o;
    logic [VC_W-1:0]   r_vc_o;
    logic              r_send;
    logic              r_err;

    // A vc_i beyond NUM_VC (only possible when NUM_VC is not a power of two)
    // is treated like a push into a full VC: the flit is dropped and flagged.
    assign w_vc_ok    = ({1'b0, vc_i} < (VC_W+1)'(NUM_VC));
    assign w_full_sel = w_vc_ok ? full_o[vc_i] : 1'b1;
    assign w_drop     = port_en && w_full_sel;

    // ------------------------------------------------------------------------
    // Per-VC flit FIFO and credit counter
    // ------------------------------------------------------------------------
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wptr;
        logic [PTR_W-1:0]  r_rptr;
        logic [OCC_W-1:0]  r_occ;
        logic [CNT_W-1:0]  r_credit;
        logic              w_push;
        logic              w_pop;
        logic              w_inc;

        // full_o is occupancy before the edge, so a same-cycle pop never
        // opens room for a push into a full VC.
        assign full_o[v]     = (r_occ == OCC_W'(DEPTH));
        assign w_push        = port_en && (vc_i == VC_W'(v)) && !full_o[v];
        assign w_pop         = w_grant_valid && (w_grant_vc == VC_W'(v));
        assign w_inc         = inc_credit_i[v];
        assign w_elig[v]     = (r_occ != '0) && (r_credit != '0);
        assign w_head[v]     = r_mem[r_rptr];
        assign w_credit[v]   = r_credit;
        // A lone credit return while already at CREDITS is an overflow;
        // return plus consume in the same cycle cancels out and is legal.
        assign w_cred_ovf[v] = w_inc && !w_pop && (r_credit == CNT_W'(CREDITS));

        // Flit storage write; contents need no reset since occupancy gates reads
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
            end
        end

        // Read/write pointers and occupancy, wrapping modulo DEPTH
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + 1'b1;
                    2'b01:   r_occ <= r_occ - 1'b1;
                    default: r_occ <= r_occ;
                endcase
            end
        end

        // Credit counter: returns add, grants consume, saturating at CREDITS
        always_ff @(posedge clk) begin
            if (rst) begin
                r_credit <= CNT_W'(CREDITS);
            end else begin
                case ({w_inc, w_pop})
                    2'b10: begin
                        if (r_credit != CNT_W'(CREDITS)) begin
                            r_credit <= r_credit + 1'b1;
                        end
                    end
                    2'b01:   r_credit <= r_credit - 1'b1;
                    default: r_credit <= r_credit;
                endcase
            end
        end

`ifndef SYNTHESIS
        // Counter and occupancy range invariants
        always_ff @(posedge clk) begin
            if (!rst) begin
                assert (r_credit <= CNT_W'(CREDITS));
                assert (r_occ <= OCC_W'(DEPTH));
            end
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Round-robin arbiter: scan from r_rr_ptr upward, wrapping modulo NUM_VC
    // ------------------------------------------------------------------------
    // First eligible VC at or after the pointer wins
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_vc    = '0;
        w_sum         = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (VC_W+1)'(i);
            if (w_sum >= (VC_W+1)'(NUM_VC)) begin
                w_sum = w_sum - (VC_W+1)'(NUM_VC);
            end
            if (!w_grant_valid && w_elig[w_sum[VC_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_vc    = w_sum[VC_W-1:0];
            end
        end
    end

    // Pointer moves one past the granted VC
    assign w_ptr_next = (w_grant_vc == VC_W'(NUM_VC - 1)) ? '0 : w_grant_vc + 1'b1;

    // Link-side output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_data_o <= '0;
            r_vc_o   <= '0;
            r_send   <= 1'b0;
        end else if (w_grant_valid) begin
            r_rr_ptr <= w_ptr_next;
            r_data_o <= w_head[w_grant_vc];
            r_vc_o   <= w_grant_vc;
            r_send   <= 1'b1;
        end else begin
            r_send   <= 1'b0;
        end
    end

    // Sticky error: dropped push or credit overflow, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_drop || (|w_cred_ovf)) begin
            r_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // A grant must never be issued against an empty credit counter
    always_ff @(posedge clk) begin
        if (!rst && w_grant_valid) begin
            assert (w_credit[w_grant_vc] != '0);
        end
    end
`endif

    assign data_o    = r_data_o;
    assign vc_o      = r_vc_o;
    assign send_data = r_send;
    assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_port_vc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_output_port_vc
//  Description : Directed bench for noc_output_port_vc with a queue-based
//                reference model compared every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_output_port_vc;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 5;
    localparam int NUM_VC  = 2;
    localparam int CREDITS = 5;
    localparam int VC_W    = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_i;
    logic [VC_W-1:0]   vc_i;
    logic              port_en;
    logic [NUM_VC-1:0] full_o;
    logic [NUM_VC-1:0] inc_credit_i;
    logic [DATA_W-1:0] data_o;
    logic [VC_W-1:0]   vc_o;
    logic              send_data;
    logic              err_o;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] mq0 [$];
    logic [DATA_W-1:0] mq1 [$];
    int                mcred [NUM_VC];
    int                mptr;
    int                m_g;
    int                m_sz [NUM_VC];
    logic              exp_send;
    logic [DATA_W-1:0] exp_data;
    logic [VC_W-1:0]   exp_vc;
    logic              exp_err;

    // Output log collected by the stimulus task
    int                log_vc [$];
    logic [DATA_W-1:0] log_data [$];

    noc_output_port_vc #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_VC (NUM_VC),
        .CREDITS(CREDITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .vc_i        (vc_i),
        .port_en     (port_en),
        .full_o      (full_o),
        .inc_credit_i(inc_credit_i),
        .data_o      (data_o),
        .vc_o        (vc_o),
        .send_data   (send_data),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: apply the port rules to abstract queues at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            mq0.delete();
            mq1.delete();
            for (int v = 0; v < NUM_VC; v++) mcred[v] = CREDITS;
            mptr     = 0;
            exp_send = 1'b0;
            exp_data = '0;
            exp_vc   = '0;
            exp_err  = 1'b0;
        end else begin
            m_sz[0] = mq0.size();
            m_sz[1] = mq1.size();
            m_g = -1;
            for (int i = 0; i < NUM_VC; i++) begin
                if (m_g < 0 && m_sz[(mptr + i) % NUM_VC] > 0 && mcred[(mptr + i) % NUM_VC] > 0)
                    m_g = (mptr + i) % NUM_VC;
            end
            if (port_en && m_sz[vc_i] == DEPTH) exp_err = 1'b1;
            if (m_g >= 0) begin
                exp_send = 1'b1;
                exp_vc   = VC_W'(m_g);
                if (m_g == 0) exp_data = mq0.pop_front();
                else          exp_data = mq1.pop_front();
                mptr = (m_g + 1) % NUM_VC;
            end else begin
                exp_send = 1'b0;
            end
            if (port_en && m_sz[vc_i] < DEPTH) begin
                if (vc_i == 0) mq0.push_back(data_i);
                else           mq1.push_back(data_i);
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (inc_credit_i[v] && m_g != v) begin
                    if (mcred[v] == CREDITS) exp_err = 1'b1;
                    else                     mcred[v]++;
                end else if (!inc_credit_i[v] && m_g == v) begin
                    mcred[v]--;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("send_data", 32'(send_data), 32'(exp_send));
            if (exp_send) begin
                check("data_o", 32'(data_o), 32'(exp_data));
                check("vc_o", 32'(vc_o), 32'(exp_vc));
            end
            check("full_o", 32'(full_o),
                  32'({mq1.size() == DEPTH, mq0.size() == DEPTH}));
            check("err_o", 32'(err_o), 32'(exp_err));
        end
    end

    // One cycle of stimulus: apply inputs, step to the next falling edge, log sends
    task automatic tick(input logic r, input logic pe, input logic [VC_W-1:0] v,
                        input logic [DATA_W-1:0] d, input logic [NUM_VC-1:0] inc);
        rst          = r;
        port_en      = pe;
        vc_i         = v;
        data_i       = d;
        inc_credit_i = inc;
        @(negedge clk);
        if (send_data) begin
            log_vc.push_back(int'(vc_o));
            log_data.push_back(data_o);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic push(input logic [VC_W-1:0] v, input logic [DATA_W-1:0] d);
        tick(1'b0, 1'b1, v, d, '0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, '0, '0);
        tick(1'b1, 1'b0, '0, '0, '0);
        chk_en = 1'b1;
        log_vc.delete();
        log_data.delete();
    endtask

    initial begin
        int exp_seq3 [8];
        int exp_seq4 [5];
        exp_seq3 = '{0, 1, 0, 1, 0, 1, 0, 1};
        exp_seq4 = '{1, 0, 1, 1, 1};

        // --- Reset, idle, then six pushes on VC0 with no credit returns
        do_reset();
        idle(2);
        check("t1_idle_send", 32'(send_data), 32'd0);
        check("t1_idle_full", 32'(full_o), 32'd0);
        check("t1_idle_err", 32'(err_o), 32'd0);
        for (int k = 0; k < 6; k++) push(1'b0, DATA_W'(16'h0100 + k));
        idle(3);
        check("t1_sends", 32'(log_vc.size()), 32'd5);
        if (log_data.size() == 5) check("t1_last_data", 32'(log_data[4]), 32'h0104);
        check("t1_stall_send", 32'(send_data), 32'd0);

        // --- Single flit on VC1, one-cycle latency, then idle
        do_reset();
        push(1'b1, 16'hA5A5);
        check("t2_edge_e", 32'(send_data), 32'd0);
        idle(1);
        check("t2_send", 32'(send_data), 32'd1);
        check("t2_data", 32'(data_o), 32'hA5A5);
        check("t2_vc", 32'(vc_o), 32'd1);
        idle(1);
        check("t2_after", 32'(send_data), 32'd0);

        // --- Both VCs backlogged: strict alternation with no bubbles
        do_reset();
        for (int k = 0; k < 8; k++) push(VC_W'(k % 2), DATA_W'(16'h3000 + k));
        idle(1);
        check("t3_len", 32'(log_vc.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_vc.size()) check("t3_seq", 32'(log_vc[k]), 32'(exp_seq3[k]));
        end

        // --- VC0 credit starvation; one returned credit releases one flit
        do_reset();
        for (int k = 0; k < 5; k++) push(1'b0, DATA_W'(16'h4000 + k));
        idle(1);
        log_vc.delete();
        push(1'b0, 16'h4A00);
        push(1'b0, 16'h4A01);
        push(1'b1, 16'h4B00);
        push(1'b1, 16'h4B01);
        idle(2);
        check("t4a_len", 32'(log_vc.size()), 32'd2);
        if (log_vc.size() == 2) begin
            check("t4a_vc0", 32'(log_vc[0]), 32'd1);
            check("t4a_vc1", 32'(log_vc[1]), 32'd1);
        end
        log_vc.delete();
        tick(1'b0, 1'b1, 1'b1, 16'h4C00, 2'b10);
        tick(1'b0, 1'b1, 1'b1, 16'h4C01, 2'b11);
        tick(1'b0, 1'b1, 1'b1, 16'h4C02, 2'b10);
        tick(1'b0, 1'b1, 1'b1, 16'h4C03, 2'b10);
        idle(3);
        check("t4b_len", 32'(log_vc.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < log_vc.size()) check("t4b_seq", 32'(log_vc[k]), 32'(exp_seq4[k]));
        end
        check("t4_err", 32'(err_o), 32'd0);

        // --- Full VC0 with zero credit: drop on VC0, accept on VC1
        do_reset();
        for (int k = 0; k < 5; k++) push(1'b0, DATA_W'(16'h5000 + k));
        idle(1);
        for (int k = 0; k < 5; k++) push(1'b0, DATA_W'(16'h5100 + k));
        check("t5_full", 32'(full_o), 32'd1);
        check("t5_err_pre", 32'(err_o), 32'd0);
        push(1'b0, 16'hDEAD);
        check("t5_err_drop", 32'(err_o), 32'd1);
        check("t5_full_hold", 32'(full_o), 32'd1);
        push(1'b1, 16'hBEEF);
        idle(1);
        check("t5_vc1_send", 32'(send_data), 32'd1);
        check("t5_vc1_vc", 32'(vc_o), 32'd1);
        check("t5_vc1_data", 32'(data_o), 32'hBEEF);

        // --- Credit overflow saturates; reset mid-burst clears everything
        do_reset();
        tick(1'b0, 1'b0, '0, '0, 2'b01);
        check("t6_ovf_err", 32'(err_o), 32'd1);
        log_vc.delete();
        for (int k = 0; k < 6; k++) push(1'b0, DATA_W'(16'h6000 + k));
        idle(2);
        check("t6_sat_sends", 32'(log_vc.size()), 32'd5);
        push(1'b1, 16'h6100);
        push(1'b1, 16'h6101);
        push(1'b1, 16'h6102);
        tick(1'b1, 1'b0, '0, '0, '0);
        check("t6_rst_send", 32'(send_data), 32'd0);
        check("t6_rst_err", 32'(err_o), 32'd0);
        check("t6_rst_full", 32'(full_o), 32'd0);
        log_vc.delete();
        idle(4);
        check("t6_empty", 32'(log_vc.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
